// File: rtl/riscv.sv
// Single-cycle RV32I core (integer subset, word loads/stores only).
// Instruction and data memories are external and combinational.
module riscv (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] mem_read_data,
    output logic [31:0] instr_addr,
    output logic [31:0] data_addr,
    output logic [31:0] mem_write_data,
    output logic        should_read_mem,
    output logic        should_write_mem
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc, pc4, next_pc;
    logic [31:0] regs [32];
    logic [31:0] rs1v, rs2v, wb;
    logic        rd_we, is_load, is_store, take;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    wire [6:0] opcode = instr[6:0];
    wire [4:0] rd     = instr[11:7];
    wire [2:0] f3     = instr[14:12];
    wire [4:0] rs1    = instr[19:15];
    wire [4:0] rs2    = instr[24:20];
    wire [6:0] f7     = instr[31:25];

    // Shared ALU for register and immediate forms; alt selects SUB / SRA.
    function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'd0, $signed(a) < $signed(b)};
            3'd3:    r = {31'd0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign rs1v  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2v  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign pc4   = pc + 32'd4;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign instr_addr       = pc;
    assign data_addr        = rs1v + (is_store ? imm_s : imm_i);
    assign mem_write_data   = rs2v;
    assign should_read_mem  = reset & is_load;
    assign should_write_mem = reset & is_store;

    // Decode/execute: next PC, writeback value and memory strobes.
    // Anything not recognised falls through the defaults and behaves as a NOP.
    always_comb begin
        next_pc  = pc4;
        rd_we    = 1'b0;
        wb       = 32'd0;
        is_load  = 1'b0;
        is_store = 1'b0;
        take     = 1'b0;
        case (opcode)
            OP_LUI:   begin rd_we = 1'b1; wb = imm_u; end
            OP_AUIPC: begin rd_we = 1'b1; wb = pc + imm_u; end
            OP_JAL:   begin rd_we = 1'b1; wb = pc4; next_pc = pc + imm_j; end
            OP_JALR: begin
                if (f3 == 3'd0) begin
                    rd_we   = 1'b1;
                    wb      = pc4;
                    next_pc = (rs1v + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                case (f3)
                    3'd0:    take = rs1v == rs2v;
                    3'd1:    take = rs1v != rs2v;
                    3'd4:    take = $signed(rs1v) <  $signed(rs2v);
                    3'd5:    take = $signed(rs1v) >= $signed(rs2v);
                    3'd6:    take = rs1v <  rs2v;
                    3'd7:    take = rs1v >= rs2v;
                    default: take = 1'b0;
                endcase
                if (take) next_pc = pc + imm_b;
            end
            OP_LOAD: begin
                if (f3 == 3'd2) begin
                    is_load = 1'b1;
                    rd_we   = 1'b1;
                    wb      = mem_read_data;
                end
            end
            OP_STORE: is_store = (f3 == 3'd2);
            OP_IMM: begin
                // Shift-immediates reuse the upper immediate bits as funct7.
                case (f3)
                    3'd1:    rd_we = (f7 == 7'h00);
                    3'd5:    rd_we = (f7 == 7'h00) || (f7 == 7'h20);
                    default: rd_we = 1'b1;
                endcase
                wb = alu(f3, (f3 == 3'd5) && f7[5], rs1v, imm_i);
            end
            OP_REG: begin
                rd_we = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
                wb    = alu(f3, f7[5], rs1v, rs2v);
            end
            default: ;
        endcase
    end

    // Program counter; reset returns fetch to address 0 immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= 32'd0;
        else        pc <= next_pc;
    end

    // Register file; x0 is never written and reads of it are forced to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (rd_we && (rd != 5'd0)) begin
            regs[rd] <= wb;
        end
    end

endmodule

// File: tb/tb_riscv.sv
// Scoreboarded bench for the single-cycle core: expected per-cycle fetch
// address and memory strobes are queued, a monitor compares on negedge.
module tb_riscv;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, mem_read_data, instr_addr, data_addr, mem_write_data;
    logic        should_read_mem, should_write_mem;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic        active = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    typedef struct {
        logic [31:0] pc;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
    } exp_t;
    exp_t q[$];

    localparam int RA = 1, T0 = 5, T1 = 6, T2 = 7, S0 = 8, S1 = 9;
    localparam int A0 = 10, A1 = 11, A2 = 12, A3 = 13, A4 = 14, A5 = 15, A6 = 16, A7 = 17;
    localparam int S2 = 18, S3 = 19, S4 = 20, S5 = 21, T3 = 28, T4 = 29, T5 = 30, T6 = 31;

    riscv dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_read_data(mem_read_data),
        .instr_addr(instr_addr), .data_addr(data_addr), .mem_write_data(mem_write_data),
        .should_read_mem(should_read_mem), .should_write_mem(should_write_mem)
    );

    always #5 clk = ~clk;

    assign instr         = imem[instr_addr[7:2]];
    assign mem_read_data = dmem[data_addr[7:2]];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
        end else if (should_write_mem) begin
            dmem[data_addr[7:2]] <= mem_write_data;
        end
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endfunction

    // Instruction encoders
    function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] s_t(int imm, int rs2, int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'd2, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] u_t(int imm20, int rd, int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] j_t(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    function automatic void put(int a, logic [31:0] w);
        imem[a[7:2]] = w;
    endfunction
    // kind: 0 plain, 1 load, 2 store
    function automatic void ex(int pc, int kind, int addr, int wd);
        exp_t e;
        e.pc = pc; e.rd = (kind == 1); e.wr = (kind == 2); e.addr = addr; e.wd = wd;
        q.push_back(e);
    endfunction

    // Monitor: one expected entry per executed cycle
    always @(negedge clk) begin
        if (active && q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("pc(exp %0h)", e.pc), instr_addr, e.pc);
            chk($sformatf("rd_en@%0h", e.pc), {31'd0, should_read_mem}, {31'd0, e.rd});
            chk($sformatf("wr_en@%0h", e.pc), {31'd0, should_write_mem}, {31'd0, e.wr});
            if (e.rd || e.wr) chk($sformatf("daddr@%0h", e.pc), data_addr, e.addr);
            if (e.wr) chk($sformatf("wdata@%0h", e.pc), mem_write_data, e.wd);
        end
    end

    task automatic run_queue(string nm);
        @(posedge clk);
        #1 reset = 1'b1;
        active = 1'b1;
        for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) chk({nm, "_timeout"}, q.size(), 0);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;

        // Program A: store/load loop closed by a taken BEQ
        put(32'h00, i_t(3, 0, 6, T0, 7'h13));      // ori  t0,x0,3
        put(32'h04, i_t(4, T0, 0, T1, 7'h13));     // addi t1,t0,4
        put(32'h08, s_t(5, T1, T0));               // sw   t1,5(t0)
        put(32'h0C, i_t(5, T0, 2, T2, 7'h03));     // lw   t2,5(t0)
        put(32'h10, b_t(-16, T2, T1, 0));          // beq  t1,t2,-16
        for (int k = 0; k < 2; k++) begin
            ex(32'h00, 0, 0, 0); ex(32'h04, 0, 0, 0); ex(32'h08, 2, 8, 7);
            ex(32'h0C, 1, 8, 0); ex(32'h10, 0, 0, 0);
        end
        ex(32'h00, 0, 0, 0); ex(32'h04, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", instr_addr, 32'd0);
        chk("rst_wr", {31'd0, should_write_mem}, 32'd0);
        chk("rst_rd", {31'd0, should_read_mem}, 32'd0);
        run_queue("progA");

        // Mid-program reset while the SW is the current instruction
        #1;
        chk("pre_rst_pc", instr_addr, 32'h8);
        chk("pre_rst_wr", {31'd0, should_write_mem}, 32'd1);
        active = 1'b0;
        reset  = 1'b0;
        #1;
        chk("mid_rst_pc", instr_addr, 32'd0);
        chk("mid_rst_wr", {31'd0, should_write_mem}, 32'd0);
        chk("mid_rst_rd", {31'd0, should_read_mem}, 32'd0);

        // Program B: x0, jumps, NOPs, compares, ALU ops, branches
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        put(32'h00, s_t(32, T1, 0));               // sw t1 (cleared by reset)
        put(32'h04, i_t(9, 0, 0, T0, 7'h13));      // addi t0,x0,9
        put(32'h08, i_t(5, 0, 0, 0, 7'h13));       // addi x0,x0,5
        put(32'h0C, r_t(0, 0, 0, 0, T0));          // add  t0,x0,x0
        put(32'h10, j_t(8, RA));                   // jal  ra,+8
        put(32'h14, j_t(8, 0));                    // jal  x0,+8
        put(32'h18, i_t(0, RA, 0, 0, 7'h67));      // jalr x0,0(ra)
        put(32'h1C, s_t(36, T0, 0));
        put(32'h20, b_t(16, 0, T0, 1));            // bne  t0,x0 (equal)
        put(32'h24, 32'h0000007F);                 // unknown opcode
        put(32'h28, s_t(40, RA, 0));
        put(32'h2C, 32'h00000FFF);                 // unknown, rd field = t6
        put(32'h30, s_t(44, T6, 0));
        put(32'h34, i_t(-1, 0, 0, T0, 7'h13));     // addi t0,x0,-1
        put(32'h38, r_t(0, 0, T0, 2, T1));         // slt  t1,t0,x0
        put(32'h3C, r_t(0, 0, T0, 3, T2));         // sltu t2,t0,x0
        put(32'h40, s_t(48, T1, 0));
        put(32'h44, s_t(52, T2, 0));
        put(32'h48, u_t(32'h80000, T3, 7'h37));    // lui  t3,0x80000
        put(32'h4C, i_t(32'h404, T3, 5, T4, 7'h13)); // srai t4,t3,4
        put(32'h50, s_t(56, T4, 0));
        put(32'h54, i_t(32'h123, 0, 0, A0, 7'h13));
        put(32'h58, i_t(-16, 0, 0, A1, 7'h13));
        put(32'h5C, r_t(32, A1, A0, 0, A2));       // sub
        put(32'h60, r_t(0, A1, A0, 4, A3));        // xor
        put(32'h64, r_t(0, A1, A0, 6, A4));        // or
        put(32'h68, r_t(0, A1, A0, 7, A5));        // and
        put(32'h6C, r_t(0, A0, A1, 5, A6));        // srl  a6,a1,a0
        put(32'h70, r_t(0, A0, A0, 1, A7));        // sll  a7,a0,a0
        put(32'h74, s_t(60, A2, 0));
        put(32'h78, s_t(64, A3, 0));
        put(32'h7C, s_t(68, A4, 0));
        put(32'h80, s_t(72, A5, 0));
        put(32'h84, s_t(76, A6, 0));
        put(32'h88, s_t(80, A7, 0));
        put(32'h8C, i_t(-1, A0, 3, T5, 7'h13));    // sltiu t5,a0,-1
        put(32'h90, i_t(5, A1, 2, T6, 7'h13));     // slti  t6,a1,5
        put(32'h94, s_t(84, T5, 0));
        put(32'h98, s_t(88, T6, 0));
        put(32'h9C, b_t(8, A0, A1, 4));            // blt  a1,a0 taken
        put(32'hA0, i_t(0, 0, 0, A0, 7'h13));      // skipped
        put(32'hA4, b_t(8, A0, A1, 6));            // bltu a1,a0 not taken
        put(32'hA8, b_t(8, A1, A0, 5));            // bge  a0,a1 taken
        put(32'hAC, i_t(0, 0, 0, A0, 7'h13));      // skipped
        put(32'hB0, b_t(8, A1, A0, 7));            // bgeu a0,a1 not taken
        put(32'hB4, u_t(1, S0, 7'h17));            // auipc s0,1
        put(32'hB8, i_t(40, 0, 2, S1, 7'h03));     // lw s1,40(x0)
        put(32'hBC, s_t(92, S0, 0));
        put(32'hC0, s_t(96, S1, 0));
        put(32'hC4, i_t(32'h0F0, A0, 4, S2, 7'h13)); // xori
        put(32'hC8, i_t(32'h7FF, A1, 7, S3, 7'h13)); // andi
        put(32'hCC, i_t(28, A1, 5, S4, 7'h13));    // srli
        put(32'hD0, i_t(4, A0, 1, S5, 7'h13));     // slli
        put(32'hD4, s_t(100, S2, 0));
        put(32'hD8, s_t(104, S3, 0));
        put(32'hDC, s_t(108, S4, 0));
        put(32'hE0, s_t(112, S5, 0));

        ex(32'h00, 2, 32'h20, 0); ex(32'h04, 0, 0, 0); ex(32'h08, 0, 0, 0);
        ex(32'h0C, 0, 0, 0); ex(32'h10, 0, 0, 0); ex(32'h18, 0, 0, 0);
        ex(32'h14, 0, 0, 0); ex(32'h1C, 2, 32'h24, 0); ex(32'h20, 0, 0, 0);
        ex(32'h24, 0, 0, 0); ex(32'h28, 2, 32'h28, 32'h14); ex(32'h2C, 0, 0, 0);
        ex(32'h30, 2, 32'h2C, 0); ex(32'h34, 0, 0, 0); ex(32'h38, 0, 0, 0);
        ex(32'h3C, 0, 0, 0); ex(32'h40, 2, 32'h30, 1); ex(32'h44, 2, 32'h34, 0);
        ex(32'h48, 0, 0, 0); ex(32'h4C, 0, 0, 0); ex(32'h50, 2, 32'h38, 32'hF8000000);
        for (int a = 32'h54; a <= 32'h70; a += 4) ex(a, 0, 0, 0);
        ex(32'h74, 2, 32'h3C, 32'h133);
        ex(32'h78, 2, 32'h40, 32'hFFFFFED3);
        ex(32'h7C, 2, 32'h44, 32'hFFFFFFF3);
        ex(32'h80, 2, 32'h48, 32'h120);
        ex(32'h84, 2, 32'h4C, 32'h1FFFFFFE);
        ex(32'h88, 2, 32'h50, 32'h918);
        ex(32'h8C, 0, 0, 0); ex(32'h90, 0, 0, 0);
        ex(32'h94, 2, 32'h54, 1); ex(32'h98, 2, 32'h58, 1);
        ex(32'h9C, 0, 0, 0); ex(32'hA4, 0, 0, 0); ex(32'hA8, 0, 0, 0);
        ex(32'hB0, 0, 0, 0); ex(32'hB4, 0, 0, 0); ex(32'hB8, 1, 32'h28, 0);
        ex(32'hBC, 2, 32'h5C, 32'h10B4); ex(32'hC0, 2, 32'h60, 32'h14);
        ex(32'hC4, 0, 0, 0); ex(32'hC8, 0, 0, 0); ex(32'hCC, 0, 0, 0); ex(32'hD0, 0, 0, 0);
        ex(32'hD4, 2, 32'h64, 32'h1D3); ex(32'hD8, 2, 32'h68, 32'h7F0);
        ex(32'hDC, 2, 32'h6C, 32'hF); ex(32'hE0, 2, 32'h70, 32'h1230);
        run_queue("progB");
        active = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv.md
RISCV -- requirements
Module: riscv

Interface
REQ-001 clk  input  1  Sole clock; all state updates on rising edge.
REQ-002 reset  input  1  Asynchronous, active-low reset.
REQ-003 instr  input  32  Instruction word at instr_addr, supplied combinationally in the same cycle.
REQ-004 mem_read_data  input  32  Data word at data_addr, supplied combinationally in the same cycle.
REQ-005 instr_addr  output  32  Byte address of the current instruction (PC).
REQ-006 data_addr  output  32  Byte address for load/store: rs1 + sign-extended immediate.
REQ-007 mem_write_data  output  32  Store data: rs2 value.
REQ-008 should_read_mem  output  1  High combinationally while the current instruction is a load.
REQ-009 should_write_mem  output  1  High combinationally while the current instruction is a store; memory writes on the next rising clk.

Function
REQ-010 The core SHALL be single-cycle: fetch, decode, execute, memory access and writeback complete within one clk period; CPI = 1.
REQ-011 The core SHALL implement RV32I integer ops:
- LUI, AUIPC
- ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
- ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
- LW, SW
- BEQ, BNE, BLT, BGE, BLTU, BGEU
- JAL, JALR
REQ-012 Immediates SHALL be sign-extended per RV32I I/S/B/U/J formats; shift amount SHALL be the low 5 bits of the shift operand.
REQ-013 SLT/SLTI SHALL compare signed; SLTU/SLTIU SHALL compare unsigned; results are 0 or 1 zero-extended.
REQ-014 All arithmetic SHALL be modulo 2^32; overflow SHALL be ignored.
REQ-015 The register file SHALL hold 32 x 32-bit registers with two combinational read ports and one write port written on the rising clk edge.
REQ-016 x0 SHALL always read 0; writes to x0 SHALL be discarded.
REQ-017 Next PC SHALL be:
- PC+4 by default
- PC + B-immediate for a taken branch
- PC + J-immediate for JAL
- (rs1 + I-immediate) with bit 0 cleared for JALR
REQ-018 JAL/JALR SHALL write PC+4 to rd.
REQ-019 LW SHALL write mem_read_data to rd in the same cycle; SW SHALL NOT write any register.
REQ-020 Only full 32-bit word accesses SHALL be supported; data_addr SHALL be output unmodified, with no alignment check or trap.
REQ-021 Unrecognised opcodes, FENCE and SYSTEM SHALL execute as NOP:
- no register write
- should_write_mem = 0
- PC+4
REQ-022 A read of a register written in the previous cycle SHALL return the new value; no forwarding is needed in a single-cycle design.

Reset
REQ-023 While reset = 0, PC SHALL be 0 and all 31 writable registers SHALL be cleared to 0, asynchronously.
REQ-024 While reset = 0, should_write_mem and should_read_mem SHALL be forced to 0 and no register write SHALL occur.
REQ-025 The first instruction fetched after reset deasserts SHALL be from address 0; PC advances on the first rising clk with reset = 1.
REQ-026 Assertion of reset mid-program SHALL immediately return instr_addr to 0 and discard the in-flight instruction.

Verification
REQ-027 Reset held low, then released -> instr_addr = 0, should_write_mem = 0, should_read_mem = 0; after release, instr_addr = 0, 4, 8 on successive cycles.
REQ-028 Program at 0:
- ori t0,x0,3; addi t1,t0,4; sw t1,5(t0); lw t2,5(t0); beq t1,t2,-16
- SW cycle -> data_addr = 8, mem_write_data = 7, should_write_mem = 1
- LW cycle -> data_addr = 8, should_read_mem = 1, t2 = 7
- BEQ -> next instr_addr = 0, loop repeats
REQ-029 addi x0,x0,5, then add t0,x0,x0 -> t0 = 0.
REQ-030 Signed vs unsigned compare:
- addi t0,x0,-1; slt t1,t0,x0 -> t1 = 1
- sltu t2,t0,x0 -> t2 = 0
- srai of 0x80000000 by 4 -> 0xF8000000
REQ-031 jal ra,+8 at PC 0x10 -> ra = 0x14, next instr_addr = 0x18; jalr x0,0(ra) -> next instr_addr = 0x14.
REQ-032 bne with equal operands at PC 0x20 -> next instr_addr = 0x24; unknown opcode 0x0000007F -> no state change, PC+4.
